alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 276 +++++++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// -----------------------------------------------------------------------------
// Purpose:
//   Two-requester round-robin front end for a shared, purely combinational
//   RV32I ALU. One operation is in flight at a time. The block decodes the
//   RV32I {funct7[5], funct3} op into ALU control signals, presents the
//   operands for exactly one cycle (EXEC), captures the ALU result and holds it
//   as a response (RESP) until the consumer accepts it.
//
// Configuration macro:
//   ALU_ARB_PIPELINE_EN - when defined, a new request may be accepted in the
//                         same cycle that a response completes (one op every
//                         2 cycles). When undefined, one IDLE cycle separates
//                         operations (one op every 3 cycles).
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset
//   i_req_valid[1:0] request valid, bit n for requester n
//   o_req_ready[1:0] request accepted this cycle, bit n (combinational)
//   i_req_op0/1      {funct7[5], funct3} of requester 0/1
//   i_req_a0/1       operand A of requester 0/1
//   i_req_b0/1       operand B of requester 0/1
//   o_rsp_valid      response valid
//   o_rsp_id         requester index of the response
//   o_rsp_result     ALU result of the response
//   i_rsp_ready      consumer accepts the response
//   o_alu_op_a/b     ALU operands (zero outside EXEC)
//   o_alu_sub        subtract / arithmetic-shift select
//   o_alu_shift_dir  0 = left, 1 = right
//   o_alu_cmp_sig    1 = signed compare
//   o_alu_bool_op    boolean select: 00 xor, 10 or, 11 and
//   o_alu_op_sel     unit select: 0001 add, 0010 cmp, 0100 bool, 1000 shift
//   i_alu_result     combinational ALU result
// -----------------------------------------------------------------------------
module alu_arbiter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_req_valid,
    output logic [1:0]  o_req_ready,
    input  logic [3:0]  i_req_op0,
    input  logic [3:0]  i_req_op1,
    input  logic [31:0] i_req_a0,
    input  logic [31:0] i_req_a1,
    input  logic [31:0] i_req_b0,
    input  logic [31:0] i_req_b1,
    output logic        o_rsp_valid,
    output logic        o_rsp_id,
    output logic [31:0] o_rsp_result,
    input  logic        i_rsp_ready,
    output logic [31:0] o_alu_op_a,
    output logic [31:0] o_alu_op_b,
    output logic        o_alu_sub,
    output logic        o_alu_shift_dir,
    output logic        o_alu_cmp_sig,
    output logic [1:0]  o_alu_bool_op,
    output logic [3:0]  o_alu_op_sel,
    input  logic [31:0] i_alu_result
);

`ifdef ALU_ARB_PIPELINE_EN
    localparam logic PIPELINE_EN = 1'b1;
`else
    localparam logic PIPELINE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef struct packed {
        logic [3:0] op_sel;
        logic       sub;
        logic       shift_dir;
        logic       cmp_sig;
        logic [1:0] bool_op;
        logic       is_shift;
    } ctrl_t;

    // Decode {funct7[5], funct3} into ALU controls. funct7[5] only matters for
    // add/sub and srl/sra; every other funct3 ignores it.
    function automatic ctrl_t decode_op(input logic [3:0] op);
        ctrl_t c;
        c = '0;
        case (op[2:0])
            3'b000: begin
                c.op_sel = 4'b0001;
                c.sub    = op[3];
            end
            3'b001: begin
                c.op_sel    = 4'b1000;
                c.shift_dir = 1'b0;
                c.is_shift  = 1'b1;
            end
            3'b101: begin
                c.op_sel    = 4'b1000;
                c.shift_dir = 1'b1;
                c.sub       = op[3];
                c.is_shift  = 1'b1;
            end
            3'b010: begin
                c.op_sel  = 4'b0010;
                c.sub     = 1'b1;
                c.cmp_sig = 1'b1;
            end
            3'b011: begin
                c.op_sel  = 4'b0010;
                c.sub     = 1'b1;
                c.cmp_sig = 1'b0;
            end
            3'b100: begin
                c.op_sel  = 4'b0100;
                c.bool_op = 2'b00;
            end
            3'b110: begin
                c.op_sel  = 4'b0100;
                c.bool_op = 2'b10;
            end
            3'b111: begin
                c.op_sel  = 4'b0100;
                c.bool_op = 2'b11;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Shift amounts are 5 bits in RV32I; the upper operand bits are cleared so
    // the ALU never sees an out-of-range shift.
    function automatic logic [31:0] shape_b(input logic is_shift, input logic [31:0] b);
        logic [31:0] r;
        if (is_shift) begin
            r = {27'b0, b[4:0]};
        end else begin
            r = b;
        end
        return r;
    endfunction

    state_t      state_r;
    logic        last_grant_r;

    logic        arb_en_s;
    logic        grant_any_s;
    logic        grant_id_s;
    logic        accept_s;
    logic [3:0]  sel_op_s;
    logic [31:0] sel_a_s;
    logic [31:0] sel_b_s;
    ctrl_t       sel_ctrl_s;

    // Arbitration window: IDLE always; RESP only while the response completes
    // and back-to-back acceptance is built in. Never while reset is asserted.
    always_comb begin
        arb_en_s = 1'b0;
        if (i_rst) begin
            arb_en_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            arb_en_s = 1'b1;
        end else if ((state_r == ST_RESP) && i_rsp_ready && PIPELINE_EN) begin
            arb_en_s = 1'b1;
        end else begin
            arb_en_s = 1'b0;
        end
    end

    // Round-robin winner: a lone requester wins; on a tie the one not granted
    // last time wins.
    always_comb begin
        grant_id_s = 1'b0;
        case (i_req_valid)
            2'b01:   grant_id_s = 1'b0;
            2'b10:   grant_id_s = 1'b1;
            2'b11:   grant_id_s = ~last_grant_r;
            default: grant_id_s = 1'b0;
        endcase
    end

    // Ready/accept and the granted requester's payload mux.
    always_comb begin
        grant_any_s = |i_req_valid;
        accept_s    = arb_en_s & grant_any_s;
        o_req_ready = 2'b00;
        if (accept_s) begin
            o_req_ready = grant_id_s ? 2'b10 : 2'b01;
        end else begin
            o_req_ready = 2'b00;
        end
        if (grant_id_s) begin
            sel_op_s = i_req_op1;
            sel_a_s  = i_req_a1;
            sel_b_s  = i_req_b1;
        end else begin
            sel_op_s = i_req_op0;
            sel_a_s  = i_req_a0;
            sel_b_s  = i_req_b0;
        end
        sel_ctrl_s = decode_op(sel_op_s);
    end

    // Main FSM. The ALU control outputs are registered at acceptance, so they
    // are valid exactly during EXEC and cleared on leaving it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r         <= ST_IDLE;
            last_grant_r    <= 1'b1;
            o_rsp_valid     <= 1'b0;
            o_rsp_id        <= 1'b0;
            o_rsp_result    <= 32'h0000_0000;
            o_alu_op_a      <= 32'h0000_0000;
            o_alu_op_b      <= 32'h0000_0000;
            o_alu_sub       <= 1'b0;
            o_alu_shift_dir <= 1'b0;
            o_alu_cmp_sig   <= 1'b0;
            o_alu_bool_op   <= 2'b00;
            o_alu_op_sel    <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_EXEC: begin
                    o_rsp_result    <= i_alu_result;
                    o_rsp_valid     <= 1'b1;
                    state_r         <= ST_RESP;
                    o_alu_op_a      <= 32'h0000_0000;
                    o_alu_op_b      <= 32'h0000_0000;
                    o_alu_sub       <= 1'b0;
                    o_alu_shift_dir <= 1'b0;
                    o_alu_cmp_sig   <= 1'b0;
                    o_alu_bool_op   <= 2'b00;
                    o_alu_op_sel    <= 4'b0000;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    o_rsp_valid     <= 1'b0;
                    o_alu_op_a      <= 32'h0000_0000;
                    o_alu_op_b      <= 32'h0000_0000;
                    o_alu_sub       <= 1'b0;
                    o_alu_shift_dir <= 1'b0;
                    o_alu_cmp_sig   <= 1'b0;
                    o_alu_bool_op   <= 2'b00;
                    o_alu_op_sel    <= 4'b0000;
                end
            endcase
            // Acceptance only happens in IDLE or a completing RESP, so it
            // never collides with the EXEC branch above.
            if (accept_s) begin
                state_r         <= ST_EXEC;
                last_grant_r    <= grant_id_s;
                o_rsp_id        <= grant_id_s;
                o_alu_op_a      <= sel_a_s;
                o_alu_op_b      <= shape_b(sel_ctrl_s.is_shift, sel_b_s);
                o_alu_sub       <= sel_ctrl_s.sub;
                o_alu_shift_dir <= sel_ctrl_s.shift_dir;
                o_alu_cmp_sig   <= sel_ctrl_s.cmp_sig;
                o_alu_bool_op   <= sel_ctrl_s.bool_op;
                o_alu_op_sel    <= sel_ctrl_s.op_sel;
            end else begin
                last_grant_r    <= last_grant_r;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: combinational ALU stub driven by the DUT controls,
// a transaction-level reference model checked every cycle, and directed tests.
module tb_alu_arbiter;

`ifdef ALU_ARB_PIPELINE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  op0, op1;
    logic [31:0] a0, a1, b0, b1;
    logic        rsp_valid, rsp_id, rsp_ready;
    logic [31:0] rsp_result;
    logic [31:0] alu_a, alu_b, alu_res;
    logic        alu_sub, alu_dir, alu_sig;
    logic [1:0]  alu_bool;
    logic [3:0]  alu_sel;

    int checks = 0;
    int fails  = 0;

    alu_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op0(op0), .i_req_op1(op1),
        .i_req_a0(a0), .i_req_a1(a1), .i_req_b0(b0), .i_req_b1(b1),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_result(rsp_result),
        .i_rsp_ready(rsp_ready),
        .o_alu_op_a(alu_a), .o_alu_op_b(alu_b),
        .o_alu_sub(alu_sub), .o_alu_shift_dir(alu_dir), .o_alu_cmp_sig(alu_sig),
        .o_alu_bool_op(alu_bool), .o_alu_op_sel(alu_sel),
        .i_alu_result(alu_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub: shifts use the full operand B so an unmasked B is visible.
    always_comb begin
        alu_res = 32'h0;
        case (alu_sel)
            4'b0001: alu_res = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
            4'b0010: alu_res = alu_sig ? {31'b0, $signed(alu_a) < $signed(alu_b)}
                                       : {31'b0, alu_a < alu_b};
            4'b0100: begin
                case (alu_bool)
                    2'b00:   alu_res = alu_a ^ alu_b;
                    2'b10:   alu_res = alu_a | alu_b;
                    2'b11:   alu_res = alu_a & alu_b;
                    default: alu_res = 32'h0;
                endcase
            end
            4'b1000: begin
                if (!alu_dir)     alu_res = alu_a << alu_b;
                else if (alu_sub) alu_res = $signed(alu_a) >>> alu_b;
                else              alu_res = alu_a >> alu_b;
            end
            default: alu_res = 32'h0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RV32I semantics straight from the instruction definitions.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op[2:0])
            3'b000:  return op[3] ? a - b : a + b;
            3'b001:  return a << sh;
            3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  return (a < b) ? 32'd1 : 32'd0;
            3'b100:  return a ^ b;
            3'b101:  return op[3] ? 32'($signed(a) >>> sh) : a >> sh;
            3'b110:  return a | b;
            3'b111:  return a & b;
            default: return 32'h0;
        endcase
    endfunction

    // Reference model: tracks whether an op is in flight and whether its
    // response is on display, and what that response must be.
    bit          m_en = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_show = 1'b0;
    bit          m_last = 1'b1;
    bit          m_id = 1'b0;
    logic [31:0] m_res = 32'h0;
    logic [31:0] m_a = 32'h0;
    int          m_done = 0;
    int          cyc = 0;
    int          grant_log[$];
    int          accept_cyc[$];

    always @(negedge clk) begin
        bit       win, can, acc;
        logic [1:0] exp_ready;
        cyc++;
        if (m_en) begin
            win = (req_valid == 2'b11) ? ~m_last : req_valid[1];
            can = !rst && (!m_busy || (PIPE && m_show && rsp_ready));
            acc = can && (req_valid != 2'b00);
            exp_ready = acc ? (win ? 2'b10 : 2'b01) : 2'b00;
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("rsp_valid", 64'(rsp_valid), 64'(m_show));
            if (m_show) begin
                check("rsp_result", 64'(rsp_result), 64'(m_res));
                check("rsp_id", 64'(rsp_id), 64'(m_id));
            end
            if (m_busy && !m_show) begin
                check("alu_op_a", 64'(alu_a), 64'(m_a));
            end else begin
                check("alu_idle_a", 64'(alu_a), 64'h0);
                check("alu_idle_b", 64'(alu_b), 64'h0);
                check("alu_idle_ctl", 64'({alu_sub, alu_dir, alu_sig, alu_bool, alu_sel}), 64'h0);
            end
            if ((req_ready & req_valid) != 2'b00) begin
                grant_log.push_back(req_ready[1] ? 1 : 0);
                accept_cyc.push_back(cyc);
            end
            if (rst) begin
                m_busy = 1'b0;
                m_show = 1'b0;
                m_last = 1'b1;
            end else begin
                if (m_show && rsp_ready) begin
                    m_show = 1'b0;
                    m_busy = 1'b0;
                    m_done++;
                end else if (m_busy && !m_show) begin
                    m_show = 1'b1;
                end
                if (acc) begin
                    m_busy = 1'b1;
                    m_show = 1'b0;
                    m_id   = win;
                    m_last = win;
                    m_a    = win ? a1 : a0;
                    m_res  = win ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
                end
            end
        end
    end

    task automatic do_op(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output bit rid, output int lat);
        int n;
        @(posedge clk); #1;
        if (id) begin op1 = op; a1 = a; b1 = b; end
        else    begin op0 = op; a0 = a; b0 = b; end
        req_valid[id] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[id] && n < 20);
        check("accept_timeout", 64'(n >= 20), 64'h0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        op0 = 4'hF; a0 = 32'hDEAD_BEEF; b0 = 32'h1234_5678;
        op1 = 4'hE; a1 = 32'hCAFE_F00D; b1 = 32'h8765_4321;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
        res = rsp_result;
        rid = rsp_id;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_busy && n < 50) begin @(negedge clk); n++; end
        check("drain_timeout", 64'(n >= 50), 64'h0);
    endtask

    task automatic wait_grants(input int target);
        int n;
        n = 0;
        while (grant_log.size() < target && n < 200) begin @(negedge clk); n++; end
        check("grant_timeout", 64'(n >= 200), 64'h0);
    endtask

    task automatic dir(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name);
        logic [31:0] r;
        bit rid;
        int lat;
        do_op(id, op, a, b, r, rid, lat);
        check({name, "_result"}, 64'(r), 64'(exp));
        check({name, "_id"}, 64'(rid), 64'(id));
        check({name, "_latency"}, 64'(lat), 64'd2);
    endtask

    initial begin
        int base, done0, span;
        logic [31:0] held;
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
        op0 = 4'h0; op1 = 4'h0; a0 = 32'h0; a1 = 32'h0; b0 = 32'h0; b1 = 32'h0;
        @(posedge clk); #1;
        m_en = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_result", 64'(rsp_result), 64'h0);
        check("rst_rsp_id", 64'(rsp_id), 64'h0);
        check("rst_alu_sel", 64'(alu_sel), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 2'b00;

        // Decode vectors with hand-computed results.
        dir(1'b0, 4'b0000, 32'd5, 32'd6, 32'd11, "add");
        dir(1'b0, 4'b1000, 32'd5, 32'd6, 32'hFFFF_FFFF, "sub");
        dir(1'b1, 4'b1101, 32'hF000_FFFF, 32'h108, 32'hFFF0_00FF, "sra");
        dir(1'b1, 4'b0011, 32'd8, 32'h8000_0000, 32'd1, "sltu");
        dir(1'b1, 4'b0010, 32'd8, 32'h8000_0000, 32'd0, "slt");
        dir(1'b0, 4'b0001, 32'd1, 32'h21, 32'd2, "sll");
        dir(1'b0, 4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, "srl");
        dir(1'b0, 4'b0100, 32'hF0F0, 32'hFF00, 32'h0FF0, "xor");
        dir(1'b1, 4'b0110, 32'hF0F0, 32'hFF00, 32'hFFF0, "or");
        dir(1'b1, 4'b0111, 32'hF0F0, 32'hFF00, 32'hF000, "and");
        dir(1'b0, 4'b1010, 32'hFFFF_FFFF, 32'd0, 32'd1, "slt_f7");
        dir(1'b1, 4'b1100, 32'd3, 32'd5, 32'd6, "xor_f7");
        drain();

        // Tie from reset: grants alternate starting with requester 0.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        op0 = 4'b0000; a0 = 32'd10; b0 = 32'd20;
        op1 = 4'b0100; a1 = 32'hFFFF; b1 = 32'd1;
        base = grant_log.size();
        req_valid = 2'b11;
        wait_grants(base + 4);
        @(posedge clk); #1 req_valid = 2'b00;
        if (grant_log.size() >= base + 4) begin
            check("rr_0", 64'(grant_log[base]), 64'd0);
            check("rr_1", 64'(grant_log[base+1]), 64'd1);
            check("rr_2", 64'(grant_log[base+2]), 64'd0);
            check("rr_3", 64'(grant_log[base+3]), 64'd1);
        end
        drain();

        // Backpressure: response held for 5 cycles, then exactly one completes.
        @(posedge clk); #1 rsp_ready = 1'b0;
        dir(1'b1, 4'b0000, 32'd100, 32'd23, 32'd123, "bp");
        @(posedge clk); #1;
        held = 32'd123;
        op0 = 4'b0000; a0 = 32'd1; b0 = 32'd1; req_valid = 2'b01;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_result", 64'(rsp_result), 64'(held));
            check("bp_hold_valid", 64'(rsp_valid), 64'd1);
            check("bp_ready_low", 64'(req_ready), 64'h0);
        end
        @(posedge clk); #1;
        done0 = m_done;
        rsp_ready = 1'b1; req_valid = 2'b00;
        repeat (4) @(negedge clk);
        check("bp_one_done", 64'(m_done - done0), 64'd1);
        drain();

        // Reset during EXEC: no response, pointer back to favour requester 0.
        @(posedge clk); #1;
        op0 = 4'b0000; a0 = 32'd7; b0 = 32'd7; req_valid = 2'b01;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!req_ready[0] && n < 20);
            check("mid_accept_timeout", 64'(n >= 20), 64'h0);
        end
        @(posedge clk); #1;
        req_valid = 2'b00; rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("mid_no_rsp", 64'(rsp_valid), 64'h0);
        end
        @(posedge clk); #1;
        base = grant_log.size();
        req_valid = 2'b11;
        wait_grants(base + 1);
        @(posedge clk); #1 req_valid = 2'b00;
        if (grant_log.size() >= base + 1)
            check("mid_tie_grant", 64'(grant_log[base]), 64'd0);
        drain();

        // Throughput: spacing of back-to-back acceptances over four ops.
        @(posedge clk); #1;
        base = accept_cyc.size();
        req_valid = 2'b11;
        wait_grants(grant_log.size() + 5);
        @(posedge clk); #1 req_valid = 2'b00;
        if (accept_cyc.size() >= base + 5) begin
            span = accept_cyc[base+4] - accept_cyc[base];
            check("throughput_4ops", 64'(span), PIPE ? 64'd8 : 64'd12);
        end
        drain();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
